// File: rtl/io_txfifo_port.sv
// io_txfifo_port: I/O-space OUT port feeding a 16-bit FIFO, with a wait-state stall when full.
// Define IO_TXFIFO_PORT_IRQ_EN to add the open-drain nirq low-water/overflow interrupt.
module io_txfifo_port #(
    parameter logic [7:0] ADDR_BASE = 8'h10,
    parameter int DEPTH = 8,
    parameter int AW = 3,
    parameter int WS_TIMEOUT = 16
`ifdef IO_TXFIFO_PORT_IRQ_EN
    , parameter int IRQ_LOW = DEPTH / 4
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ndev,
    input  logic        nio,
    input  logic        nr,
    input  logic        nw,
    input  logic [7:0]  ab,
    inout  wire  [15:0] db,
    output wire         nws,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
`ifdef IO_TXFIFO_PORT_IRQ_EN
    , output wire       nirq
`endif
);
    typedef enum logic [1:0] {IDLE, STALL, DONE} state_t;
    state_t state;
    logic [15:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_next;
    logic [AW:0] count, count_next;
    logic [7:0] timer;
    logic overflow, sel, wsel, rsel, full, empty, pop, push, drop, irq;
    logic [15:0] head_next, status;
    assign sel = !ndev && !nio && (ab[7:1] == ADDR_BASE[7:1]);
    assign wsel = sel && !nw && !ab[0];
    // a simultaneous write strobe wins, so a read only counts with nw high
    assign rsel = sel && !nr && nw;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign tx_valid = !empty;
    assign pop = !empty && tx_ready;
    assign push = (state == IDLE && wsel && (!full || pop)) || (state == STALL && pop);
    assign drop = state == STALL && !pop && timer == 8'd0;
    assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);
    assign rd_next = pop ? rd_ptr + 1'b1 : rd_ptr;
    // head bypasses storage when the word being written becomes the head
    assign head_next = (count_next == '0) ? 16'h0000 :
                       (push && rd_next == wr_ptr) ? db : mem[rd_next];
`ifdef IO_TXFIFO_PORT_IRQ_EN
    localparam logic [AW:0] IRQ_LVL = (AW+1)'(IRQ_LOW);
    assign irq = (count <= IRQ_LVL) || overflow;
    assign nirq = (!reset && irq) ? 1'b0 : 1'bz;
`else
    assign irq = 1'b0;
`endif
    assign status = {overflow, full, empty, irq, 5'b0, 7'(count)};
    assign db = rsel ? (ab[0] ? status : tx_data) : 16'bz;
    assign nws = ((state == IDLE && wsel && full) || state == STALL) ? 1'b0 : 1'bz;
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= db;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            timer <= '0;
            overflow <= 1'b0;
            tx_data <= 16'h0000;
        end else begin
            count <= count_next;
            tx_data <= head_next;
            rd_ptr <= rd_next;
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            overflow <= drop || (overflow && !(rsel && ab[0]));
            case (state)
                IDLE: if (wsel) begin
                    state <= (full && !pop) ? STALL : DONE;
                    timer <= 8'(WS_TIMEOUT - 1);
                end
                STALL: begin
                    state <= (pop || timer == 8'd0) ? DONE : STALL;
                    timer <= (pop || timer == 8'd0) ? timer : timer - 8'd1;
                end
                DONE: state <= (!sel || nw) ? IDLE : DONE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_io_txfifo_port.sv
// tb_io_txfifo_port: randomized scoreboard bench for io_txfifo_port against a queue-based model.
module tb_io_txfifo_port;
    localparam int DEPTH = 8;
    localparam int WS = 16;
    localparam logic [7:0] BASE = 8'h10;
    logic clk = 0, reset = 1, ndev = 1, nio = 1, nr = 1, nw = 1, ready = 0, db_oe = 0;
    logic [7:0] ab = 8'h00;
    logic [15:0] db_drv = 16'h0000;
    wire [15:0] db;
    wire nws;
    logic [15:0] tx_data;
    logic tx_valid;
    int checks = 0, errors = 0;
    logic [15:0] exp_q[$];
    bit mov = 0;
    assign db = db_oe ? db_drv : 16'bz;
    pullup (nws);
`ifdef IO_TXFIFO_PORT_IRQ_EN
    wire nirq;
    pullup (nirq);
`endif
    io_txfifo_port dut (
        .clk(clk), .reset(reset), .ndev(ndev), .nio(nio), .nr(nr), .nw(nw), .ab(ab),
        .db(db), .nws(nws), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(ready)
`ifdef IO_TXFIFO_PORT_IRQ_EN
        , .nirq(nirq)
`endif
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    // scoreboard monitor: every accepted head must be the oldest expected word
    always @(negedge clk)
        if (!reset && tx_valid && ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_pop: got %h expected no word", tx_data);
            end else check("tx_data", tx_data, exp_q.pop_front());
        end
    function automatic bit exp_irq();
`ifdef IO_TXFIFO_PORT_IRQ_EN
        return (exp_q.size() <= DEPTH / 4) || mov;
`else
        return 1'b0;
`endif
    endfunction
    function automatic logic [15:0] exp_status();
        int n = exp_q.size();
        return {mov, 1'(n == DEPTH), 1'(n == 0), exp_irq(), 5'b0, 7'(n)};
    endfunction
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic bus_idle();
        ndev = 1; nio = 1; nr = 1; nw = 1; db_oe = 0;
    endtask
    task automatic write_word(input logic [15:0] d, input int rel, input int hold, input bit rr);
        bit pushed = 0;
        ready = rr ? 1'($urandom) : 1'b0;
        ndev = 0; nio = 0; ab = BASE; nw = 0; db_drv = d; db_oe = 1;
        if (exp_q.size() < DEPTH || ready) begin
            exp_q.push_back(d);
            cyc();
            ready = 0;
        end else begin
            #1 check("nws_first", nws, 1'b0);
            cyc();
            for (int j = 0; j < WS; j++) begin
                check("nws_stall", nws, 1'b0);
                if (j == rel) begin
                    ready = 1;
                    exp_q.push_back(d);
                    cyc();
                    ready = 0;
                    pushed = 1;
                    break;
                end
                cyc();
            end
            if (!pushed) mov = 1;
        end
        repeat (hold) cyc();
        check("nws_release", nws, 1'b1);
        bus_idle();
        cyc();
    endtask
    task automatic write_odd(input logic [15:0] d);
        ready = 0;
        ndev = 0; nio = 0; ab = BASE | 8'h01; nw = 0; db_drv = d; db_oe = 1;
        #1 check("nws_odd", nws, 1'b1);
        cyc();
        bus_idle();
        cyc();
    endtask
    task automatic read_status();
        ready = 0;
        ndev = 0; nio = 0; ab = BASE | 8'h01; nr = 0;
        #1 check("status", db, exp_status());
`ifdef IO_TXFIFO_PORT_IRQ_EN
        check("nirq", nirq, !exp_irq());
`endif
        cyc();
        mov = 0;
        bus_idle();
        cyc();
    endtask
    task automatic peek();
        ready = 0;
        ndev = 0; nio = 0; ab = BASE; nr = 0;
        #1 check("peek", db, exp_q.size() != 0 ? exp_q[0] : 16'h0000);
        cyc();
        bus_idle();
        cyc();
    endtask
    task automatic idle(input int n, input bit rr);
        repeat (n) begin
            ready = rr ? 1'($urandom) : 1'b0;
            cyc();
        end
        ready = 0;
    endtask
    task automatic drain();
        ready = 1;
        repeat (DEPTH + 2) cyc();
        ready = 0;
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1, "timeout");
    end
    initial begin
        cyc();
        cyc();
        check("rst_valid", tx_valid, 1'b0);
        check("rst_data", tx_data, 16'h0000);
        check("rst_nws", nws, 1'b1);
`ifdef IO_TXFIFO_PORT_IRQ_EN
        check("rst_nirq", nirq, 1'b1);
`endif
        reset = 0;
        cyc();
        write_word(16'h1111, -1, 0, 0);
        write_word(16'h2222, -1, 0, 0);
        write_word(16'h3333, -1, 0, 0);
        read_status();
        peek();
        ready = 1;
        repeat (3) cyc();
        ready = 0;
        read_status();
        peek();
        for (int i = 0; i < DEPTH; i++) write_word(16'hA000 + 16'(i), -1, 0, 0);
        write_word(16'hBEEF, WS + 5, 0, 0);
        read_status();
        read_status();
        write_word(16'hCAFE, 5, 0, 0);
        read_status();
        drain();
        read_status();
        write_word(16'h5555, -1, 10, 0);
        read_status();
        write_odd(16'h7777);
        read_status();
        drain();
        repeat (300) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: write_word(16'($urandom), $urandom_range(0, WS + 3), $urandom_range(0, 2), 1);
                5, 6: idle($urandom_range(1, 4), 1);
                7: read_status();
                8: peek();
                default: write_odd(16'($urandom));
            endcase
        end
        drain();
        read_status();
        while (exp_q.size() < DEPTH) write_word(16'($urandom), -1, 0, 0);
        ready = 0;
        ndev = 0; nio = 0; ab = BASE; nw = 0; db_drv = 16'hDEAD; db_oe = 1;
        repeat (4) cyc();
        reset = 1;
        #1 check("rst_stall_nws", nws, 1'b1);
        check("rst_stall_valid", tx_valid, 1'b0);
`ifdef IO_TXFIFO_PORT_IRQ_EN
        check("rst_stall_nirq", nirq, 1'b1);
`endif
        exp_q.delete();
        mov = 0;
        bus_idle();
        cyc();
        reset = 0;
        cyc();
        read_status();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/io_txfifo_port.md
Name: io_txfifo_port

Overview:
- I/O-space slave on the CFT backplane. It sits directly downstream of the bus board's address decoder and databus driver, and consumes niodevNxx, ab, db, nio, nr and nw.
- CPU OUT cycles push 16-bit words into a DEPTH-entry FIFO, which a local consumer (UART/DAC/etc. logic on the same card) drains through a valid/ready handshake.
- When the FIFO is full, the block asserts the open-drain nws wait-state line to stall the processor. After WS_TIMEOUT cycles it gives up and drops the word.

Parameters:
- ADDR_BASE, 8'h10: I/O offset within the selected niodev window. Bit 0 is ignored; the block decodes 2 addresses.
- DEPTH, 8: FIFO entries; power of 2, 2..64.
- AW, 3: log2(DEPTH).
- WS_TIMEOUT, 16: maximum stall cycles before a write is dropped; 1..255.

Ports:
- clk  in  1  bus clock (clk1 domain); all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- ndev  in  1  active-low window select (one of niodev1xx/2xx/3xx).
- nio  in  1  active-low I/O cycle.
- nr  in  1  active-low read strobe.
- nw  in  1  active-low write strobe.
- ab  in  8  ab[7:0].
- db  inout  16  data bus; driven only during a selected read, else Z.
- nws  out  1  open drain: drives 0 or Z, never 1.
- tx_data  out  16  FIFO head word.
- tx_valid  out  1  FIFO not empty.
- tx_ready  in  1  consumer accepts the head on a clock where tx_valid&tx_ready.

Behaviour:
- Select: sel = !ndev & !nio & (ab[7:1]==ADDR_BASE[7:1]).
  - wsel = sel & !nw, at offset 0 only.
  - rsel = sel & !nr, at either offset.
- Reset (async) values:
  - FIFO empty; count=0; rd/wr pointers 0.
  - overflow flag 0; state IDLE.
  - tx_valid=0; tx_data=16'h0000; nws=Z; db=Z.
- FIFO storage:
  - count is AW+1 bits; pointers wrap modulo DEPTH.
  - full = (count==DEPTH); empty = (count==0).
- State machine:
  - IDLE:
    - wsel & !full → push db, go to DONE.
    - wsel & full → go to STALL, load timer = WS_TIMEOUT-1.
  - STALL: nws=0.
    - If a pop frees space this cycle, push db on the same edge and go to DONE.
    - Else if timer==0, set overflow=1, discard the word, go to DONE.
    - Else decrement timer.
  - DONE: nws=Z; no further push. Return to IDLE when nw deasserts or sel drops.
  - Result: exactly one push (or drop) per write strobe, however long nw stays low.
- nws is combinational: 0 when (state==IDLE & wsel & full) or state==STALL. This lets the stall reach the databus unit in the same cycle the write begins.
- Simultaneous push and pop: count is unchanged, both pointers advance. A pop while full in IDLE with wsel present: the push happens, no stall.
- Pop: on tx_valid & tx_ready, rd_ptr+1, count-1. tx_data is the registered head and updates on the same edge. No pop occurs when empty; tx_ready is ignored then.
- Reads (combinational drive while rsel):
  - Offset 0 (peek): head word; 16'h0000 when empty.
  - Offset 1 (status): {overflow, full, empty, 6'b0, count zero-extended to 7 bits}, i.e. bit15 overflow, bit14 full, bit13 empty, bits6:0 count.
  - A status read clears overflow on the first edge with rsel at offset 1. If a new overflow occurs in the same cycle, set wins.
- Write to offset 1: ignored; no stall.
- Reset mid-stall: FIFO cleared, nws released immediately (asynchronously), and the pending word is lost.
- nr and nw both low is illegal; the write path takes priority and db is not driven.

Optional Feature:
- Macro: IO_TXFIFO_PORT_IRQ_EN.
- With the macro defined, the block adds:
  - Port nirq (out, 1, open drain).
  - Parameter IRQ_LOW, default DEPTH/4.
  - nirq=0 while count<=IRQ_LOW or overflow==1, else Z; Z during reset.
  - Status bit12 = irq pending.
- Without the macro: no nirq port; status bit12 reads 0.

Test Plan:
- Reset, then 3 OUT writes (16'h1111, 16'h2222, 16'h3333) to offset 0 with tx_ready=0 → status reads 16'h0003. Then assert tx_ready 3 cycles → tx_data 1111, 2222, 3333; status 16'h2000.
- Fill 8 words, 9th write with tx_ready=0 → nws=0 from the first cycle, held 16 cycles, then released. Status reads 16'hC008, and a second read returns 16'h4008.
- Full FIFO, 9th write, assert tx_ready for one cycle at stall cycle 5 → nws releases on that edge. The 9th word is enqueued last; no overflow.
- Hold nw low for 10 cycles on one write → count increments by exactly 1.
- Assert reset at stall cycle 3 → nws=Z and tx_valid=0 before the next clock edge; status reads 16'h2000.
- IRQ_EN build: count 2 → nirq=0; push to 3 → nirq=Z; force an overflow → nirq=0 until a status read.
